trap_filter_prog: RTL and testbench

// - Run-time programmable trapezoidal shaper for one ADC channel; successor to the fixed-K/L/M filter.
//   d=v(n)-v(n-k)-v(n-l)+v(n-k-l); p+=d; r=p+m*d; s+=r; out=s>>>SHIFT.
// - Adds sample-valid gating, a load/flush state machine, range checking and output clipping.
// - Sits between the ADC capture stage and the peak/energy logic.

---
 rtl/trap_pkg.sv | 34 +++
 rtl/trap_delay_line.sv | 50 +++++
 rtl/trap_filter_prog.sv | 226 ++++++++++++++++++++++
 tb/tb_trap_filter_prog.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// -----------------------------------------------------------------------------
// trap_pkg
// Shared types and constants for the programmable trapezoidal shaper.
//   trap_state_t  : FLUSH / RUN sequencing state
//   trap_cfg_t    : active shaping configuration {k, l, m}
//   PIPE_LAT      : strobes from S0 to the output register
//   K_MAX, M_W    : maximum rise length and width of the m multiplier
//   trap_cfg_ok() : legality check applied to every configuration load
// -----------------------------------------------------------------------------
package trap_pkg;

  localparam int PIPE_LAT = 6;
  localparam int K_MAX    = 32;
  localparam int KL_W     = 6;
  localparam int M_W      = 8;

  typedef enum logic {
    FLUSH = 1'b0,
    RUN   = 1'b1
  } trap_state_t;

  typedef struct packed {
    logic [KL_W-1:0] k;
    logic [KL_W-1:0] l;
    logic [M_W-1:0]  m;
  } trap_cfg_t;

  // A load is legal when 1 <= l <= k <= K_MAX.
  function automatic logic trap_cfg_ok(input logic [KL_W-1:0] k,
                                       input logic [KL_W-1:0] l);
    return (l != '0) && (l <= k) && (int'(k) <= K_MAX);
  endfunction

endpackage

// File: rtl/trap_delay_line.sv
// -----------------------------------------------------------------------------
// trap_delay_line
// Enable-gated sample shift register with 2*K_MAX+1 taps. tap[0] holds the
// newest accepted sample, tap[i] the sample accepted i strobes earlier.
// Ports:
//   clk_i, rst_ni     clock, synchronous active-low reset (clears all taps)
//   clr_i             synchronous clear (same effect as reset)
//   en_i              shift strobe; taps hold when low
//   din_i             sample written into tap[0]
//   idx_k_i/_l_i/_kl_i  tap selects; out-of-range selects read 0
//   tap0_o, tap_k_o, tap_l_o, tap_kl_o  selected tap values
// -----------------------------------------------------------------------------
module trap_delay_line #(
  parameter int W     = 14,
  parameter int DEPTH = 65,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [W-1:0]     din_i,
  input  logic [IDX_W-1:0] idx_k_i,
  input  logic [IDX_W-1:0] idx_l_i,
  input  logic [IDX_W-1:0] idx_kl_i,
  output logic [W-1:0]     tap0_o,
  output logic [W-1:0]     tap_k_o,
  output logic [W-1:0]     tap_l_o,
  output logic [W-1:0]     tap_kl_o
);

  logic [W-1:0] tap_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_i) begin
      for (int i = 0; i < DEPTH; i++) tap_q[i] <= '0;
    end else if (en_i) begin
      tap_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) tap_q[i] <= tap_q[i-1];
    end
  end

  always_comb begin
    tap0_o   = tap_q[0];
    tap_k_o  = (idx_k_i  < IDX_W'(DEPTH)) ? tap_q[idx_k_i]  : '0;
    tap_l_o  = (idx_l_i  < IDX_W'(DEPTH)) ? tap_q[idx_l_i]  : '0;
    tap_kl_o = (idx_kl_i < IDX_W'(DEPTH)) ? tap_q[idx_kl_i] : '0;
  end

endmodule

// File: rtl/trap_filter_prog.sv
// -----------------------------------------------------------------------------
// trap_filter_prog
// Run-time programmable trapezoidal shaper for one ADC channel:
//   d = v(n)-v(n-k)-v(n-l)+v(n-k-l); p += d; r = p + m*d; s += r;
//   output = clip(s >>> SHIFT)
// Build option: TRAP_FILTER_SAT_EN
//   defined     -> output saturates to the signed OUT_W range, sat_flag sticky
//   not defined -> output is the low OUT_W bits, sat_flag tied 0
// Ports:
//   clk, reset (sync, active-low)
//   input_data, in_valid         ADC sample and its strobe
//   cfg_k, cfg_l, cfg_m, cfg_load configuration and its 1-cycle apply strobe
//   cfg_err                      sticky: last load was rejected
//   busy                         high while flushing
//   output_data, out_valid       filtered sample and its 1-cycle qualifier
//   sat_flag                     sticky clip indicator
//
// state | meaning
// FLUSH | pipeline refilling after reset/legal load; output held at 0
// RUN   | every accepted sample produces an output strobe
// -----------------------------------------------------------------------------
module trap_filter_prog
  import trap_pkg::*;
#(
  parameter int ADC_W = 14,
  parameter int OUT_W = 16,
  parameter int ACC_W = 32,
  parameter int SHIFT = 7,
  parameter int K_DEF = 8,
  parameter int L_DEF = 5,
  parameter int M_DEF = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADC_W-1:0]        input_data,
  input  logic                    in_valid,
  input  logic [KL_W-1:0]         cfg_k,
  input  logic [KL_W-1:0]         cfg_l,
  input  logic [M_W-1:0]          cfg_m,
  input  logic                    cfg_load,
  output logic                    cfg_err,
  output logic                    busy,
  output logic signed [OUT_W-1:0] output_data,
  output logic                    out_valid,
  output logic                    sat_flag
);

  localparam int DEPTH = 2*K_MAX + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 7;

  localparam trap_cfg_t CFG_DEF = '{k: KL_W'(K_DEF), l: KL_W'(L_DEF), m: M_W'(M_DEF)};

  trap_state_t state_q, state_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  trap_cfg_t cfg_q;
  logic cfg_err_q;

  logic signed [ACC_W-1:0] d_q, d2_q, p_q, md_q, r_q, s_q;
  logic signed [ACC_W-1:0] d_d, md_d;
  logic signed [ACC_W-1:0] x0, xk, xl, xkl, m_ext;
  logic signed [OUT_W-1:0] out_q, clip_v;
  logic out_valid_q;

  logic load_ok, load_bad, adv, flush_last, emit;
  logic [ADC_W-1:0] tap0, tap_k, tap_l, tap_kl;

  // A load always consumes the cycle, so a coincident sample is dropped.
  assign load_ok  = cfg_load && trap_cfg_ok(cfg_k, cfg_l);
  assign load_bad = cfg_load && !trap_cfg_ok(cfg_k, cfg_l);
  assign adv      = in_valid && !cfg_load;

  assign flush_last = (flush_cnt_q == (CNT_W'(cfg_q.k) + CNT_W'(cfg_q.l) + CNT_W'(PIPE_LAT - 1)));

  trap_delay_line #(
    .W     (ADC_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_delay (
    .clk_i    (clk),
    .rst_ni   (reset),
    .clr_i    (load_ok),
    .en_i     (adv),
    .din_i    (input_data),
    .idx_k_i  (IDX_W'(cfg_q.k)),
    .idx_l_i  (IDX_W'(cfg_q.l)),
    .idx_kl_i (IDX_W'(cfg_q.k) + IDX_W'(cfg_q.l)),
    .tap0_o   (tap0),
    .tap_k_o  (tap_k),
    .tap_l_o  (tap_l),
    .tap_kl_o (tap_kl)
  );

  // ---------------------------------------------------------------------------
  // Sequencing FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FLUSH;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The strobe that completes the flush already drives the first output.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    emit        = 1'b0;
    if (load_ok) begin
      state_d     = FLUSH;
      flush_cnt_d = '0;
    end else if (adv) begin
      case (state_q)
        FLUSH: begin
          if (flush_last) begin
            state_d = RUN;
            emit    = 1'b1;
          end else begin
            flush_cnt_d = flush_cnt_q + 1'b1;
          end
        end
        RUN:     emit = 1'b1;
        default: state_d = FLUSH;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath arithmetic
  // ---------------------------------------------------------------------------
`ifdef TRAP_FILTER_SAT_EN
  localparam logic signed [ACC_W-1:0] OUT_MAX =
    $signed({{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;
  logic signed [ACC_W-1:0] s_shift;
  logic sat_hit;
`endif

  always_comb begin
    // Samples are unsigned; zero-extend before the signed difference.
    x0    = $signed({{(ACC_W-ADC_W){1'b0}}, tap0});
    xk    = $signed({{(ACC_W-ADC_W){1'b0}}, tap_k});
    xl    = $signed({{(ACC_W-ADC_W){1'b0}}, tap_l});
    xkl   = $signed({{(ACC_W-ADC_W){1'b0}}, tap_kl});
    m_ext = $signed({{(ACC_W-M_W){1'b0}}, cfg_q.m});
    d_d   = x0 - xk - xl + xkl;
    md_d  = m_ext * d2_q;
`ifdef TRAP_FILTER_SAT_EN
    s_shift = s_q >>> SHIFT;
    sat_hit = 1'b0;
    if (s_shift > OUT_MAX) begin
      clip_v  = OUT_W'(OUT_MAX);
      sat_hit = 1'b1;
    end else if (s_shift < OUT_MIN) begin
      clip_v  = OUT_W'(OUT_MIN);
      sat_hit = 1'b1;
    end else begin
      clip_v  = OUT_W'(s_shift);
    end
`else
    clip_v = OUT_W'(s_q >>> SHIFT);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cfg_q       <= CFG_DEF;
      cfg_err_q   <= 1'b0;
      d_q         <= '0;
      d2_q        <= '0;
      p_q         <= '0;
      md_q        <= '0;
      r_q         <= '0;
      s_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= emit;
      if (load_ok) begin
        cfg_q     <= '{k: cfg_k, l: cfg_l, m: cfg_m};
        cfg_err_q <= 1'b0;
        d_q       <= '0;
        d2_q      <= '0;
        p_q       <= '0;
        md_q      <= '0;
        r_q       <= '0;
        s_q       <= '0;
        out_q     <= '0;
      end else begin
        if (load_bad) cfg_err_q <= 1'b1;
        if (adv) begin
          d_q  <= d_d;
          d2_q <= d_q;
          p_q  <= p_q + d2_q;
          md_q <= md_d;
          r_q  <= p_q + md_q;
          s_q  <= s_q + r_q;
          if (emit) out_q <= clip_v;
        end
      end
    end
  end

`ifdef TRAP_FILTER_SAT_EN
  logic sat_q;
  always_ff @(posedge clk) begin
    if (!reset || load_ok) begin
      sat_q <= 1'b0;
    end else if (emit && sat_hit) begin
      sat_q <= 1'b1;
    end
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign cfg_err     = cfg_err_q;
  assign busy        = (state_q == FLUSH);
  assign output_data = out_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_trap_filter_prog.sv
module tb_trap_filter_prog;

  localparam int ADC_W = 14;
`ifdef TRAP_FILTER_SAT_EN
  localparam int OUT_W = 8;
`else
  localparam int OUT_W = 16;
`endif
  localparam int SHIFT = 2;
  localparam int LAT   = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [ADC_W-1:0] input_data = '0;
  logic in_valid = 1'b0;
  logic [5:0] cfg_k = '0;
  logic [5:0] cfg_l = '0;
  logic [7:0] cfg_m = '0;
  logic cfg_load = 1'b0;
  logic cfg_err, busy, out_valid, sat_flag;
  logic signed [OUT_W-1:0] output_data;

  always #5 clk = ~clk;

  trap_filter_prog #(
    .ADC_W(ADC_W), .OUT_W(OUT_W), .ACC_W(32), .SHIFT(SHIFT),
    .K_DEF(8), .L_DEF(5), .M_DEF(16)
  ) dut (
    .clk(clk), .reset(reset), .input_data(input_data), .in_valid(in_valid),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m), .cfg_load(cfg_load),
    .cfg_err(cfg_err), .busy(busy), .output_data(output_data),
    .out_valid(out_valid), .sat_flag(sat_flag)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: sample history since the last clear, running sums.
  int hist[$];
  int ys[$];
  bit hits[$];
  int k_m, l_m, m_m, p_m, s_m, out_m;
  bit run_m, err_m, sat_m, ov_m;

  function automatic int xh(input int i);
    return (i < 0) ? 0 : hist[i];
  endfunction

  function automatic int clip_f(input int v, output bit hit);
`ifdef TRAP_FILTER_SAT_EN
    hit = 1'b0;
    if (v > 2**(OUT_W-1) - 1) begin hit = 1'b1; return 2**(OUT_W-1) - 1; end
    if (v < -(2**(OUT_W-1)))  begin hit = 1'b1; return -(2**(OUT_W-1)); end
    return v;
`else
    logic signed [OUT_W-1:0] t;
    hit = 1'b0;
    t = OUT_W'(v);
    return int'(t);
`endif
  endfunction

  task automatic model_clear();
    hist.delete(); ys.delete(); hits.delete();
    p_m = 0; s_m = 0; out_m = 0;
    run_m = 0; sat_m = 0; ov_m = 0;
  endtask

  task automatic model_step(input bit v, input int x, input bit ld,
                            input int k, input int l, input int m);
    int n, d, y;
    bit h;
    ov_m = 0;
    if (ld) begin
      if (l >= 1 && l <= k && k <= 32) begin
        k_m = k; l_m = l; m_m = m;
        model_clear();
        err_m = 0;
      end else begin
        err_m = 1;
      end
    end else if (v) begin
      hist.push_back(x);
      n = hist.size() - 1;
      d = xh(n) - xh(n - k_m) - xh(n - l_m) + xh(n - k_m - l_m);
      p_m = p_m + d;
      s_m = s_m + p_m + m_m * d;
      y = clip_f(s_m >>> SHIFT, h);
      ys.push_back(y);
      hits.push_back(h);
      if (n >= k_m + l_m + LAT - 1) begin
        run_m = 1;
        ov_m  = 1;
        out_m = ys[n - LAT];
        if (hits[n - LAT]) sat_m = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, ov_m);
    chk("output_data", output_data, out_m);
    chk("busy", busy, !run_m);
    chk("cfg_err", cfg_err, err_m);
    chk("sat_flag", sat_flag, sat_m);
  endtask

  // Called at a negedge; drives one cycle and checks at the next negedge.
  task automatic cyc(input bit v, input int x, input bit ld,
                     input int k, input int l, input int m);
    in_valid = v; input_data = ADC_W'(x); cfg_load = ld;
    cfg_k = 6'(k); cfg_l = 6'(l); cfg_m = 8'(m);
    @(posedge clk);
    model_step(v, x, ld, k, l, m);
    @(negedge clk);
    in_valid = 1'b0; cfg_load = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    k_m = 8; l_m = 5; m_m = 16; err_m = 0;
    model_clear();
    check_all();
    reset = 1'b1;
  endtask

  int step_exp[12] = '{0, 0, 0, 0, 0, 0, 10, 30, 50, 70, 80, 80};
  int nb, first_ov, rk, rl, rm, peak;

  initial begin
    do_reset();

    // Default config: 20 strobes of 100.
    nb = 0; first_ov = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nb++;
      cyc(1, 100, 0, 0, 0, 0);
      if (out_valid && first_ov == 0) first_ov = i + 1;
    end
    chk("busy_strobes", nb, 19);
    chk("first_ov", first_ov, 19);

    // k=4 l=2 m=0: flush on 0, then step of 40 (>>2 gives 10-based ramp).
    cyc(0, 0, 1, 4, 2, 0);
    for (int i = 0; i < 12; i++) cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(1, 40, 0, 0, 0, 0);
      chk("step_out", output_data, step_exp[i]);
    end

    // Illegal loads leave config and state alone.
    cyc(0, 0, 1, 2, 3, 7);
    chk("illegal_err", cfg_err, 1);
    cyc(1, 40, 0, 0, 0, 0);
    cyc(0, 0, 1, 33, 1, 9);
    cyc(0, 0, 1, 5, 0, 9);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 0, 0, 0);

    // Random configs and data, gated and continuous valid.
    for (int c = 0; c < 4; c++) begin
      rk = $urandom_range(1, 32);
      rl = $urandom_range(1, rk);
      rm = $urandom_range(0, 255);
      cyc(0, 0, 1, rk, rl, rm);
      for (int t = 0; t < 240; t++) begin
        if (t == 100) cyc(0, 0, 1, 5, 7, 3);
        else cyc((c % 2 == 0) ? ((t % 3) == 0) : bit'($urandom_range(0, 1)),
                 $urandom_range(0, 2**ADC_W - 1), 0, 0, 0, 0);
      end
    end

    // Load coincident with a sample mid-RUN: sample dropped, flush restarts.
    cyc(1, 1234, 1, rk, rl, rm);
    chk("reload_busy", busy, 1);
    first_ov = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1, $urandom_range(0, 2**ADC_W - 1), 0, 0, 0, 0);
      if (out_valid && first_ov == 0) first_ov = i + 1;
    end
    chk("reload_first_ov", first_ov, rk + rl + 6);

    // Large step: clip behaviour.
    cyc(0, 0, 1, 8, 5, 16);
    for (int i = 0; i < 19; i++) cyc(1, 0, 0, 0, 0, 0);
    peak = 0;
    for (int i = 0; i < 30; i++) begin
      cyc(1, 2**ADC_W - 1, 0, 0, 0, 0);
      if (int'(output_data) > peak) peak = int'(output_data);
    end
`ifdef TRAP_FILTER_SAT_EN
    chk("sat_peak", peak, 127);
    chk("sat_flag_set", sat_flag, 1);
`endif
    cyc(0, 0, 1, 8, 5, 16);
    chk("sat_cleared", sat_flag, 0);

    do_reset();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
